// File: rtl/irq_arbiter.sv
// Interrupt/trap sequencer between the CLINT and EX: accepts one event in IDLE,
// stalls the pipeline, writes mepc/mcause/mstatus (or mstatus for mret) and redirects fetch.
module irq_arbiter #(
  parameter int          XLEN        = 32,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            timer_irq_i,
  input  logic            soft_irq_i,
  input  logic            ext_irq_i,
  input  logic            inst_valid_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            hold_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_addr_o
);

  typedef enum logic [2:0] {
    IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, MRET_WR, JUMP
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic            is_mret_q;

  logic            accept_trap;
  logic            accept_mret;
  logic [XLEN-1:0] cause_d;
  logic [XLEN-1:0] trap_mstatus;
  logic [XLEN-1:0] mret_mstatus;
  logic            unused_bits;

  // Only the MSIE/MTIE/MEIE bits of mie and the aligned part of mtvec matter.
  assign unused_bits = ^{mie_i, mtvec_i[1:0]};

  always_comb begin
    accept_trap = 1'b0;
    accept_mret = 1'b0;
    cause_d     = '0;
    if (state_q == IDLE && inst_valid_i && !rst) begin
      if (ecall_i) begin
        accept_trap = 1'b1;
        cause_d     = XLEN'(11);
      end else if (ebreak_i) begin
        accept_trap = 1'b1;
        cause_d     = XLEN'(3);
      end else if (mret_i) begin
        accept_mret = 1'b1;
      end else if (mstatus_i[3] && mie_i[11] && ext_irq_i) begin
        accept_trap = 1'b1;
        cause_d     = {1'b1, (XLEN-1)'(11)};
      end else if (mstatus_i[3] && mie_i[3] && soft_irq_i) begin
        accept_trap = 1'b1;
        cause_d     = {1'b1, (XLEN-1)'(3)};
      end else if (mstatus_i[3] && mie_i[7] && timer_irq_i) begin
        accept_trap = 1'b1;
        cause_d     = {1'b1, (XLEN-1)'(7)};
      end
    end
  end

  always_comb begin
    trap_mstatus    = mstatus_i;
    trap_mstatus[7] = mstatus_i[3];
    trap_mstatus[3] = 1'b0;
    mret_mstatus    = mstatus_i;
    mret_mstatus[3] = mstatus_i[7];
    mret_mstatus[7] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      is_mret_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_trap) begin
            epc_q     <= inst_addr_i;
            cause_q   <= cause_d;
            is_mret_q <= 1'b0;
            state_q   <= WR_MEPC;
          end else if (accept_mret) begin
            epc_q     <= inst_addr_i;
            is_mret_q <= 1'b1;
            state_q   <= MRET_WR;
          end
        end
        WR_MEPC:    state_q <= WR_MCAUSE;
        WR_MCAUSE:  state_q <= WR_MSTATUS;
        WR_MSTATUS: state_q <= JUMP;
        MRET_WR:    state_q <= JUMP;
        JUMP:       state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  // Write strobes and redirect decode straight from the state flop; mstatus/mepc
  // are taken live in the cycle they are used.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    case (state_q)
      WR_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_q;
      end
      WR_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      WR_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = trap_mstatus;
      end
      MRET_WR: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mret_mstatus;
      end
      JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = is_mret_q ? mepc_i : {mtvec_i[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign hold_o = (state_q != IDLE) || accept_trap || accept_mret;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: table of single-event vectors plus hand-written
// sequences for reset abort and level re-acceptance.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_irq_i, soft_irq_i, ext_irq_i, inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        ecall_i, ebreak_i, mret_i;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        hold_o, csr_we_o, jump_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, jump_addr_o;

  int checks = 0;
  int errors = 0;

  irq_arbiter dut (
    .clk(clk), .rst(rst),
    .timer_irq_i(timer_irq_i), .soft_irq_i(soft_irq_i), .ext_irq_i(ext_irq_i),
    .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .hold_o(hold_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tmr, sft, ext, ecall, ebreak, mret, valid;
    logic [31:0] pc, mstatus, mie, mtvec, mepc;
    int          kind;   // 0 none, 1 trap, 2 mret
    logic [31:0] cause, ms_wr, jaddr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    timer_irq_i = 0; soft_irq_i = 0; ext_irq_i = 0;
    ecall_i = 0; ebreak_i = 0; mret_i = 0; inst_valid_i = 0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_hold"}, {31'b0, hold_o}, 32'd0);
    chk({name, "_we"}, {31'b0, csr_we_o}, 32'd0);
    chk({name, "_jump"}, {31'b0, jump_o}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    timer_irq_i = v.tmr; soft_irq_i = v.sft; ext_irq_i = v.ext;
    ecall_i = v.ecall; ebreak_i = v.ebreak; mret_i = v.mret; inst_valid_i = v.valid;
    inst_addr_i = v.pc; mstatus_i = v.mstatus; mie_i = v.mie;
    mtvec_i = v.mtvec; mepc_i = v.mepc;
    #1;
    chk({tag, "_accept_hold"}, {31'b0, hold_o}, (v.kind != 0) ? 32'd1 : 32'd0);
    if (v.kind == 0) begin
      repeat (4) begin
        tick();
        chk_quiet({tag, "_idle"});
      end
      clear_events();
    end else if (v.kind == 1) begin
      tick(); clear_events();
      chk({tag, "_mepc_we"}, {31'b0, csr_we_o}, 32'd1);
      chk({tag, "_mepc_addr"}, {20'b0, csr_waddr_o}, 32'h341);
      chk({tag, "_mepc_data"}, csr_wdata_o, v.pc);
      tick();
      chk({tag, "_mcause_addr"}, {20'b0, csr_waddr_o}, 32'h342);
      chk({tag, "_mcause_data"}, csr_wdata_o, v.cause);
      tick();
      chk({tag, "_mstatus_addr"}, {20'b0, csr_waddr_o}, 32'h300);
      chk({tag, "_mstatus_data"}, csr_wdata_o, v.ms_wr);
      chk({tag, "_mstatus_hold"}, {31'b0, hold_o}, 32'd1);
      tick();
      chk({tag, "_jump"}, {31'b0, jump_o}, 32'd1);
      chk({tag, "_jump_addr"}, jump_addr_o, v.jaddr);
      chk({tag, "_jump_we"}, {31'b0, csr_we_o}, 32'd0);
      tick();
      chk_quiet({tag, "_after"});
    end else begin
      tick(); clear_events();
      chk({tag, "_mret_we"}, {31'b0, csr_we_o}, 32'd1);
      chk({tag, "_mret_addr"}, {20'b0, csr_waddr_o}, 32'h300);
      chk({tag, "_mret_data"}, csr_wdata_o, v.ms_wr);
      tick();
      chk({tag, "_jump"}, {31'b0, jump_o}, 32'd1);
      chk({tag, "_jump_addr"}, jump_addr_o, v.jaddr);
      tick();
      chk_quiet({tag, "_after"});
    end
  endtask

  function automatic vec_t mk(input logic tmr, sft, ext, ecall, ebreak, mret, valid,
                              input logic [31:0] pc, mstatus, mie, mtvec, mepc,
                              input int kind, input logic [31:0] cause, ms_wr, jaddr);
    vec_t v;
    v.tmr = tmr; v.sft = sft; v.ext = ext; v.ecall = ecall; v.ebreak = ebreak;
    v.mret = mret; v.valid = valid; v.pc = pc; v.mstatus = mstatus; v.mie = mie;
    v.mtvec = mtvec; v.mepc = mepc; v.kind = kind; v.cause = cause;
    v.ms_wr = ms_wr; v.jaddr = jaddr;
    return v;
  endfunction

  initial begin
    //          tmr sft ext eca ebr mrt vld  pc      mstatus   mie     mtvec    mepc     kind cause         ms_wr     jaddr
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 1, 32'h100, 32'h8,    32'h80,  32'h80,  32'h0,   1, 32'h80000007, 32'h80,   32'h80);
    vecs[1]  = mk(0, 0, 0, 1, 0, 0, 1, 32'h200, 32'h0,    32'h0,   32'h1000,32'h0,   1, 32'd11,       32'h0,    32'h1000);
    vecs[2]  = mk(1, 1, 1, 0, 0, 0, 1, 32'h300, 32'h8,    32'h888, 32'h83,  32'h0,   1, 32'h8000000B, 32'h80,   32'h80);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 1, 32'h50,  32'h80,   32'h0,   32'h80,  32'h104, 2, 32'h0,        32'h88,   32'h104);
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 1, 32'h100, 32'h8,    32'h0,   32'h80,  32'h0,   0, 32'h0,        32'h0,    32'h0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 1, 32'h100, 32'h0,    32'h80,  32'h80,  32'h0,   0, 32'h0,        32'h0,    32'h0);
    vecs[6]  = mk(1, 0, 0, 0, 1, 0, 1, 32'h700, 32'h1808, 32'h80,  32'h2000,32'h0,   1, 32'd3,        32'h1880, 32'h2000);
    vecs[7]  = mk(1, 1, 0, 0, 0, 0, 1, 32'h400, 32'h88,   32'h88,  32'h84,  32'h0,   1, 32'h80000003, 32'h80,   32'h84);
    vecs[8]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h200, 32'h8,    32'h0,   32'h80,  32'h0,   0, 32'h0,        32'h0,    32'h0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1, 1, 32'h60,  32'h08,   32'h0,   32'h80,  32'h204, 2, 32'h0,        32'h80,   32'h204);
    vecs[10] = mk(0, 0, 1, 0, 0, 0, 1, 32'h500, 32'h08,   32'h800, 32'h100, 32'h0,   1, 32'h8000000B, 32'h80,   32'h100);
    vecs[11] = mk(0, 0, 1, 0, 0, 1, 1, 32'h70,  32'h88,   32'h800, 32'h100, 32'h300, 2, 32'h0,        32'h88,   32'h300);

    rst = 1; clear_events();
    inst_addr_i = 0; mstatus_i = 0; mie_i = 0; mtvec_i = 0; mepc_i = 0;
    repeat (3) tick();
    chk_quiet("reset");
    chk("reset_addr", {20'b0, csr_waddr_o}, 32'h0);
    chk("reset_jaddr", jump_addr_o, 32'h0);
    rst = 0;
    tick();
    chk_quiet("post_reset");

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset during WR_MCAUSE aborts without mstatus write or jump.
    timer_irq_i = 1; inst_valid_i = 1; inst_addr_i = 32'h100;
    mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h80;
    tick(); clear_events();
    chk("rst_mepc_addr", {20'b0, csr_waddr_o}, 32'h341);
    tick();
    chk("rst_mcause_addr", {20'b0, csr_waddr_o}, 32'h342);
    rst = 1;
    tick();
    chk_quiet("rst_abort");
    chk("rst_abort_addr", {20'b0, csr_waddr_o}, 32'h0);
    rst = 0;
    repeat (4) begin
      tick();
      chk_quiet("rst_after");
    end

    // Level held through the sequence is retaken on return to IDLE; ecall raised mid-sequence is ignored.
    timer_irq_i = 1; inst_valid_i = 1; inst_addr_i = 32'h600;
    mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h40;
    tick();
    ecall_i = 1;
    chk("lvl_mepc_data", csr_wdata_o, 32'h600);
    tick();
    ecall_i = 0;
    chk("lvl_mcause_data", csr_wdata_o, 32'h80000007);
    tick();
    chk("lvl_mstatus_data", csr_wdata_o, 32'h80);
    tick();
    chk("lvl_jump_addr", jump_addr_o, 32'h40);
    tick();
    chk("lvl_reaccept_hold", {31'b0, hold_o}, 32'd1);
    chk("lvl_reaccept_jump", {31'b0, jump_o}, 32'd0);
    tick();
    chk("lvl_reaccept_addr", {20'b0, csr_waddr_o}, 32'h341);
    chk("lvl_reaccept_data", csr_wdata_o, 32'h600);
    clear_events();
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk_quiet("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
